// File: rtl/wb_sched.sv
// wb_sched: writeback-bus reservation scheduler.
// Tracks how many shared result buses are already claimed for each of the
// next MAX_LAT cycles and grants issue only when the target slot has room.
// Requesters that keep losing are promoted ahead of the normal order.
module wb_sched #(
    parameter int NUM_FUS    = 4,
    parameter int WB_PORTS   = 2,
    parameter int MAX_LAT    = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_FUS-1:0]                req,
    input  logic [NUM_FUS-1:0][8:0]           req_lat,
    input  logic                              flush,
    output logic [NUM_FUS-1:0]                grant,
    output logic [$clog2(WB_PORTS+1)-1:0]     wb_cnt,
    output logic                              lat_err
);

    localparam int CW = $clog2(WB_PORTS + 1);
    localparam int DW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0]      occ     [0:MAX_LAT];
    logic [CW-1:0]      add     [1:MAX_LAT];
    logic [DW-1:0]      den     [NUM_FUS];
    logic [NUM_FUS-1:0] legal;
    logic [NUM_FUS-1:0] promoted;
    logic [NUM_FUS-1:0] grant_c;

    // Per-requester latency legality and starvation promotion.
    always_comb begin
        legal    = '0;
        promoted = '0;
        for (int unsigned i = 0; i < NUM_FUS; i++) begin
            legal[i]    = (req_lat[i] >= 9'd1) && (req_lat[i] <= 9'(MAX_LAT));
            promoted[i] = (den[i] == DW'(STARVE_LIM));
        end
    end

    // Priority-ordered grant: pass 0 serves promoted requesters, pass 1 the
    // rest. Grants are tallied per slot so a full slot only blocks requests
    // aimed at that same slot.
    always_comb begin
        grant_c = '0;
        for (int unsigned k = 1; k <= MAX_LAT; k++) add[k] = '0;
        if (!rst && !flush) begin
            for (int unsigned p = 0; p < 2; p++) begin
                for (int unsigned i = 0; i < NUM_FUS; i++) begin
                    if (req[i] && legal[i] && (promoted[i] == (p == 0))) begin
                        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                            if (req_lat[i] == 9'(k) &&
                                (int'(occ[k]) + int'(add[k])) < WB_PORTS) begin
                                grant_c[i] = 1'b1;
                                add[k]     = add[k] + CW'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    assign grant  = grant_c;
    assign wb_cnt = occ[0];

    // Occupancy shift with new reservations, denial counters, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k <= MAX_LAT; k++) occ[k] <= '0;
            for (int unsigned i = 0; i < NUM_FUS; i++) den[i] <= '0;
            lat_err <= 1'b0;
        end else begin
            lat_err <= lat_err | (|(req & ~legal));
            if (flush) begin
                for (int unsigned k = 0; k <= MAX_LAT; k++) occ[k] <= '0;
                for (int unsigned i = 0; i < NUM_FUS; i++) den[i] <= '0;
            end else begin
                for (int unsigned k = 0; k < MAX_LAT; k++)
                    occ[k] <= occ[k+1] + add[k+1];
                occ[MAX_LAT] <= '0;
                for (int unsigned i = 0; i < NUM_FUS; i++) begin
                    if (req[i] && !grant_c[i]) begin
                        if (den[i] != DW'(STARVE_LIM)) den[i] <= den[i] + DW'(1);
                    end else begin
                        den[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed table of per-cycle vectors plus hand-written
// sequences for starvation, flush, latency errors and mid-cycle reset.
module tb_wb_sched;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req = '0;
    logic [3:0][8:0] req_lat = '0;
    logic            flush = 1'b0;
    logic [3:0]      grant;
    logic [1:0]      wb_cnt;
    logic            lat_err;

    int checks   = 0;
    int failures = 0;

    wb_sched #(.NUM_FUS(4), .WB_PORTS(2), .MAX_LAT(16), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_lat(req_lat), .flush(flush),
        .grant(grant), .wb_cnt(wb_cnt), .lat_err(lat_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         l0, l1, l2, l3;
        logic [3:0] g;
        logic [1:0] wb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] r, int a, int b, int c, int d,
                                logic [3:0] g, logic [1:0] wb);
        vec_t v;
        v.req = r; v.l0 = a; v.l1 = b; v.l2 = c; v.l3 = d; v.g = g; v.wb = wb;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [3:0] r, int a, int b, int c, int d, logic f);
        req        = r;
        req_lat[0] = 9'(a);
        req_lat[1] = 9'(b);
        req_lat[2] = 9'(c);
        req_lat[3] = 9'(d);
        flush      = f;
    endtask

    // Apply a reset pulse and return just after a falling edge.
    task automatic do_reset();
        @(negedge clk);
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, with requests present to show grant is held low.
        drive(4'b1111, 3, 3, 3, 3, 1'b0);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_wb_cnt", wb_cnt, 0);
        chk("rst_lat_err", lat_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Consecutive cycles; grant/wb_cnt checked before each rising edge.
        tbl.push_back(mk(4'b1111, 3, 3, 3, 3, 4'b0011, 0)); // all L=3 -> two win
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 2)); // t+3
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0101, 1, 0, 4, 0, 4'b0101, 0)); // L=1 and L=4
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1)); // t+1
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1)); // t+4
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b1111, 2, 2, 2, 5, 4'b1011, 0)); // pipe2 loses, pipe3 other slot
        tbl.push_back(mk(4'b0001, 1, 0, 0, 0, 4'b0000, 0)); // slot already full
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 2));
        tbl.push_back(mk(4'b0001, 16, 0, 0, 0, 4'b0001, 0)); // MAX_LAT is legal
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1)); // L=5 lands

        foreach (tbl[n]) begin
            drive(tbl[n].req, tbl[n].l0, tbl[n].l1, tbl[n].l2, tbl[n].l3, 1'b0);
            #1;
            chk($sformatf("tbl%0d_grant", n), grant, tbl[n].g);
            chk($sformatf("tbl%0d_wb_cnt", n), wb_cnt, tbl[n].wb);
            @(negedge clk);
        end
        chk("tbl_lat_err", lat_err, 0);

        // Starvation: pipe 3 loses four times, then is promoted.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(4'b1011, 2, 2, 0, 2, 1'b0);
            #1;
            chk($sformatf("starve_c%0d", c), grant,
                (c < 4) ? 4'b0011 : (c == 4) ? 4'b1001 : 4'b0011);
            @(negedge clk);
        end

        // Flush discards reservations made two cycles earlier.
        do_reset();
        drive(4'b0011, 5, 5, 0, 0, 1'b0);
        #1 chk("flush_resv", grant, 4'b0011);
        @(negedge clk);
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        drive(4'b0011, 1, 1, 0, 0, 1'b1);
        #1 chk("flush_grant", grant, 0);
        @(negedge clk);
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("flush_wb_c%0d", c), wb_cnt, 0);
            @(negedge clk);
        end

        // Illegal latencies: never granted, lat_err sticky until reset.
        do_reset();
        drive(4'b0010, 0, 0, 0, 0, 1'b0);
        #1 chk("lat0_grant", grant, 0);
        chk("lat0_err_before", lat_err, 0);
        @(negedge clk);
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        #1 chk("lat0_err_after", lat_err, 1);
        @(negedge clk);
        drive(4'b0010, 0, 17, 0, 0, 1'b0);
        #1 chk("lat17_grant", grant, 0);
        @(negedge clk);
        drive(4'b0000, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        #1 chk("lat_err_sticky", lat_err, 1);

        // Asynchronous reset between edges with occ[2]=2 and lat_err set.
        do_reset();
        drive(4'b1011, 3, 3, 0, 0, 1'b0);
        #1 chk("arst_setup", grant, 4'b0011);
        @(posedge clk);
        #2;
        drive(4'b1111, 2, 2, 2, 2, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_wb_cnt", wb_cnt, 0);
        chk("arst_lat_err", lat_err, 0);
        chk("arst_grant", grant, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0011, 2, 2, 0, 0, 1'b0);
        #1 chk("arst_regrant", grant, 4'b0011);
        @(negedge clk);
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        #1 chk("arst_stale_wb", wb_cnt, 0);
        @(negedge clk);
        #1 chk("arst_new_wb", wb_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
